// File: rtl/mole_sprite_renderer_if.sv
// Raster, control and pattern-ROM signals shared by the VGA front end and one mole renderer.
// master drives raster/control/ROM data; slave is the renderer.
interface mole_sprite_renderer_if;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on;
   logic        frame_tick;
   logic [9:0]  mole_x;
   logic [9:0]  mole_y;
   logic        pop_req;
   logic        hit;
   logic [4:0]  rom_row;
   logic [63:0] rom_pattern;
   logic        pixel_on;
   logic        whacked;
   logic        hit_ack;
   logic        busy;

   modport master (
      output pixel_x, pixel_y, video_on, frame_tick, mole_x, mole_y,
             pop_req, hit, rom_pattern,
      input  rom_row, pixel_on, whacked, hit_ack, busy
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, frame_tick, mole_x, mole_y,
             pop_req, hit, rom_pattern,
      output rom_row, pixel_on, whacked, hit_ack, busy
   );
endinterface

// File: rtl/mole_sprite_renderer.sv
// One mole: frame-stepped pop/hold/whack/sink FSM plus a pixel pipeline into a 32x64 pattern ROM.
// pixel_on lags pixel_x/y by 2 cycles; no backpressure, a new raster coordinate is accepted every cycle.
module mole_sprite_renderer #(
   parameter int RISE_STEP    = 4,
   parameter int UP_FRAMES    = 60,
   parameter int WHACK_FRAMES = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   mole_sprite_renderer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_HIDDEN,
      S_RISING,
      S_UP,
      S_SINKING,
      S_WHACKED
   } state_t;

   localparam logic [5:0] STEP       = 6'(RISE_STEP);
   localparam logic [5:0] FULL_H     = 6'd32;
   localparam logic [6:0] UP_LAST    = 7'(UP_FRAMES - 1);
   localparam logic [6:0] WHACK_LAST = 7'(WHACK_FRAMES - 1);

   state_t     state_q, state_d;
   logic [5:0] h_q, h_d;
   logic [6:0] frame_cnt_q, frame_cnt_d;
   logic       hit_ack_q, hit_ack_d;
   logic       busy_q;
   logic       whacked_q;

   // Hit is checked before frame_tick so a strike always wins the cycle.
   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      frame_cnt_d = frame_cnt_q;
      hit_ack_d   = 1'b0;
      case (state_q)
         S_HIDDEN: begin
            h_d = 6'd0;
            if (bus.pop_req) begin
               state_d = S_RISING;
            end
         end
         S_RISING: begin
            if (bus.hit) begin
               state_d     = S_WHACKED;
               frame_cnt_d = 7'd0;
               hit_ack_d   = 1'b1;
            end else if (bus.frame_tick) begin
               h_d = h_q + STEP;
               if (h_q + STEP == FULL_H) begin
                  state_d     = S_UP;
                  frame_cnt_d = 7'd0;
               end
            end
         end
         S_UP: begin
            if (bus.hit) begin
               state_d     = S_WHACKED;
               frame_cnt_d = 7'd0;
               hit_ack_d   = 1'b1;
            end else if (bus.frame_tick) begin
               if (frame_cnt_q == UP_LAST) begin
                  state_d = S_SINKING;
               end else begin
                  frame_cnt_d = frame_cnt_q + 7'd1;
               end
            end
         end
         S_SINKING: begin
            if (bus.frame_tick) begin
               h_d = h_q - STEP;
               if (h_q == STEP) begin
                  state_d = S_HIDDEN;
               end
            end
         end
         S_WHACKED: begin
            if (bus.frame_tick) begin
               if (frame_cnt_q == WHACK_LAST) begin
                  state_d = S_HIDDEN;
                  h_d     = 6'd0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 7'd1;
               end
            end
         end
         default: begin
            state_d = S_HIDDEN;
            h_d     = 6'd0;
         end
      endcase
   end

   // busy/whacked decode the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HIDDEN;
         h_q         <= 6'd0;
         frame_cnt_q <= 7'd0;
         hit_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
         whacked_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         frame_cnt_q <= frame_cnt_d;
         hit_ack_q   <= hit_ack_d;
         busy_q      <= (state_d != S_HIDDEN);
         whacked_q   <= (state_d == S_WHACKED);
      end
   end

   // Box tests run in 11 bits so the right/bottom edges never wrap near 1023.
   logic [10:0] px, py, mx, my;
   logic [10:0] x_end, y_rim, top;
   logic        in_box_d;
   logic [4:0]  rom_row_d;
   logic [5:0]  col_d;

   assign px        = {1'b0, bus.pixel_x};
   assign py        = {1'b0, bus.pixel_y};
   assign mx        = {1'b0, bus.mole_x};
   assign my        = {1'b0, bus.mole_y};
   assign x_end     = mx + 11'd64;
   assign y_rim     = my + 11'd32;
   assign top       = y_rim - {5'd0, h_q};
   assign in_box_d  = bus.video_on && (px >= mx) && (px < x_end) &&
                      (py >= top) && (py < y_rim) && (h_q != 6'd0);
   assign rom_row_d = bus.pixel_y[4:0] - top[4:0];
   assign col_d     = bus.pixel_x[5:0] - bus.mole_x[5:0];

   logic [4:0] rom_row_q;
   logic [5:0] col_q;
   logic       in_box_q;
   logic       pixel_on_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_row_q  <= 5'd0;
         col_q      <= 6'd0;
         in_box_q   <= 1'b0;
         pixel_on_q <= 1'b0;
      end else begin
         rom_row_q  <= rom_row_d;
         col_q      <= col_d;
         in_box_q   <= in_box_d;
         pixel_on_q <= in_box_q & bus.rom_pattern[6'd63 - col_q];
      end
   end

   assign bus.rom_row  = rom_row_q;
   assign bus.pixel_on = pixel_on_q;
   assign bus.whacked  = whacked_q;
   assign bus.hit_ack  = hit_ack_q;
   assign bus.busy     = busy_q;

endmodule
